// File: rtl/s32x_fb_write_engine_if.sv
// Host write/read, fill control and draw-port bundle for the 32X framebuffer write engine.
interface s32x_fb_write_engine_if #(
  parameter int ADDR_W     = 16,
  parameter int FILL_LEN_W = 8
);
  logic                  CE;
  logic                  BLOCK;
  logic                  H_WR;
  logic [ADDR_W:0]       H_ADDR;
  logic [15:0]           H_DI;
  logic [1:0]            H_BE;
  logic                  H_FULL;
  logic                  H_EMPTY;
  logic                  H_OVF;
  logic                  H_RD;
  logic [ADDR_W-1:0]     H_RD_ADDR;
  logic                  H_RD_ACK;
  logic [15:0]           H_DO;
  logic                  FILL_START;
  logic [ADDR_W-1:0]     FILL_ADDR;
  logic [15:0]           FILL_DATA;
  logic [FILL_LEN_W-1:0] FILL_LEN;
  logic                  FILL_BUSY;
  logic [ADDR_W-1:0]     FILL_ADDR_CUR;
  logic [ADDR_W-1:0]     FB_A;
  logic [15:0]           FB_DO;
  logic [1:0]            FB_WE;
  logic                  FB_RD;
  logic [15:0]           FB_DI;

  modport master (
    output CE, BLOCK, H_WR, H_ADDR, H_DI, H_BE, H_RD, H_RD_ADDR,
           FILL_START, FILL_ADDR, FILL_DATA, FILL_LEN, FB_DI,
    input  H_FULL, H_EMPTY, H_OVF, H_RD_ACK, H_DO, FILL_BUSY, FILL_ADDR_CUR,
           FB_A, FB_DO, FB_WE, FB_RD
  );

  modport slave (
    input  CE, BLOCK, H_WR, H_ADDR, H_DI, H_BE, H_RD, H_RD_ADDR,
           FILL_START, FILL_ADDR, FILL_DATA, FILL_LEN, FB_DI,
    output H_FULL, H_EMPTY, H_OVF, H_RD_ACK, H_DO, FILL_BUSY, FILL_ADDR_CUR,
           FB_A, FB_DO, FB_WE, FB_RD
  );
endinterface

// File: rtl/s32x_fb_write_engine.sv
// 32X framebuffer write engine: host write FIFO with overwrite byte masking, paced auto-fill
// and a host read path, arbitrated onto a single draw port.
module s32x_fb_write_engine #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 4,
  parameter int FILL_LEN_W  = 8,
  parameter int WRAP_W      = 8,
  parameter int WR_HOLD     = 5,
  parameter int RD_HOLD     = 7,
  parameter int FILL_PERIOD = 3
) (
  input logic                   CLK,
  input logic                   RST_N,
  s32x_fb_write_engine_if.slave bus
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int LVL_W    = PTR_W + 1;
  localparam int ENT_W    = ADDR_W + 1 + 2 + 16;
  localparam int HOLD_MAX = (WR_HOLD > RD_HOLD) ? WR_HOLD : RD_HOLD;
  localparam int HOLD_W   = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam int PH_W     = (FILL_PERIOD < 2) ? 1 : $clog2(FILL_PERIOD);

  localparam logic [ADDR_W-1:0] WRAP_MASK = {ADDR_W{1'b1}} >> (ADDR_W - WRAP_W);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DRAIN     = 3'd1;
  localparam logic [2:0] ST_READ      = 3'd2;
  localparam logic [2:0] ST_FILL_PEND = 3'd3;
  localparam logic [2:0] ST_FILL      = 3'd4;

  // Overwrite region never writes a zero byte; the normal region only suppresses zero single-byte writes.
  function automatic logic [1:0] lane_we(input logic ow, input logic [1:0] be, input logic [15:0] d);
    logic [1:0] nz;
    nz = {|d[15:8], |d[7:0]};
    if (!ow && (be == 2'b11)) lane_we = 2'b11;
    else                      lane_we = be & nz;
  endfunction

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    wrap_inc = (a & ~WRAP_MASK) | ((a + ADDR_W'(1)) & WRAP_MASK);
  endfunction

  logic [ENT_W-1:0]      mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0]      level_r, level_s;
  logic                  full_r, empty_r, ovf_r;
  logic                  full_now_s, push_ok_s, pop_s;
  logic [ENT_W-1:0]      head_s;

  logic [2:0]            st_r, st_s;
  logic [HOLD_W-1:0]     cnt_r, cnt_s;
  logic [PH_W-1:0]       ph_r, ph_s;
  logic [FILL_LEN_W-1:0] fcnt_r, fcnt_s;
  logic [ADDR_W-1:0]     fadr_r, fadr_s;
  logic [15:0]           fdat_r, fdat_s;
  logic                  fbusy_r, fbusy_s;
  logic [ADDR_W-1:0]     fb_a_r, fb_a_s;
  logic [15:0]           fb_do_r, fb_do_s;
  logic [1:0]            fb_we_r, fb_we_s;
  logic                  fb_rd_r, fb_rd_s;
  logic                  ack_r, ack_s;
  logic [15:0]           do_r, do_s;

  assign full_now_s = (level_r == LVL_W'(DEPTH));
  assign push_ok_s  = bus.H_WR && !full_now_s;
  assign head_s     = mem_r[rd_ptr_r];

  // Next-state, draw-port and fill-register computation.
  always_comb begin
    st_s    = st_r;
    cnt_s   = cnt_r;
    ph_s    = ph_r;
    fb_a_s  = fb_a_r;
    fb_do_s = fb_do_r;
    fb_we_s = fb_we_r;
    fb_rd_s = fb_rd_r;
    ack_s   = 1'b0;
    do_s    = do_r;
    pop_s   = 1'b0;

    if (bus.FILL_START && !fbusy_r) begin
      fadr_s  = bus.FILL_ADDR;
      fdat_s  = bus.FILL_DATA;
      fcnt_s  = bus.FILL_LEN;
      fbusy_s = 1'b1;
    end else begin
      fadr_s  = fadr_r;
      fdat_s  = fdat_r;
      fcnt_s  = fcnt_r;
      fbusy_s = fbusy_r;
    end

    case (st_r)
      ST_IDLE: begin
        if (fbusy_r) begin
          st_s = ST_FILL_PEND;
        end else if ((level_r != {LVL_W{1'b0}}) && !bus.BLOCK) begin
          st_s    = ST_DRAIN;
          pop_s   = 1'b1;
          cnt_s   = {HOLD_W{1'b0}};
          fb_a_s  = head_s[ENT_W-2 -: ADDR_W];
          fb_do_s = head_s[15:0];
          fb_we_s = lane_we(head_s[ENT_W-1], head_s[17:16], head_s[15:0]);
        end else if (bus.H_RD && empty_r && !ack_r && !bus.BLOCK) begin
          // The ack cycle is skipped so a host dropping H_RD on ack does not re-trigger.
          st_s    = ST_READ;
          cnt_s   = {HOLD_W{1'b0}};
          fb_a_s  = bus.H_RD_ADDR;
          fb_rd_s = 1'b1;
        end else begin
          st_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (cnt_r == HOLD_W'(WR_HOLD)) begin
          st_s    = ST_IDLE;
          fb_we_s = 2'b00;
        end else begin
          cnt_s = cnt_r + HOLD_W'(1);
        end
      end
      ST_READ: begin
        if (cnt_r == HOLD_W'(RD_HOLD)) begin
          st_s    = ST_IDLE;
          fb_rd_s = 1'b0;
          do_s    = bus.FB_DI;
          ack_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + HOLD_W'(1);
        end
      end
      ST_FILL_PEND: begin
        if (bus.CE && !bus.BLOCK) begin
          st_s    = ST_FILL;
          ph_s    = {PH_W{1'b0}};
          fb_a_s  = fadr_r;
          fb_do_s = fdat_r;
          fb_we_s = 2'b11;
        end else begin
          st_s = ST_FILL_PEND;
        end
      end
      ST_FILL: begin
        if (bus.CE) begin
          if (ph_r == PH_W'(FILL_PERIOD - 1)) begin
            ph_s   = {PH_W{1'b0}};
            fadr_s = wrap_inc(fadr_r);
            if (fcnt_r == {FILL_LEN_W{1'b0}}) begin
              st_s    = ST_IDLE;
              fbusy_s = 1'b0;
              fb_we_s = 2'b00;
            end else begin
              fcnt_s  = fcnt_r - FILL_LEN_W'(1);
              fb_a_s  = wrap_inc(fadr_r);
              fb_do_s = fdat_r;
              fb_we_s = 2'b11;
            end
          end else begin
            ph_s    = ph_r + PH_W'(1);
            fb_we_s = 2'b00;
          end
        end else begin
          ph_s = ph_r;
        end
      end
      default: begin
        st_s    = ST_IDLE;
        fb_we_s = 2'b00;
        fb_rd_s = 1'b0;
      end
    endcase
  end

  // FIFO level; a push while full is rejected even when a pop frees a slot this cycle.
  always_comb begin
    level_s = level_r + {{(LVL_W-1){1'b0}}, push_ok_s} - {{(LVL_W-1){1'b0}}, pop_s};
  end

  // FIFO storage (data only, no reset needed).
  always_ff @(posedge CLK) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= {bus.H_ADDR, bus.H_BE, bus.H_DI};
  end

  // State, pointers, flags and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      ovf_r    <= 1'b0;
      st_r     <= ST_IDLE;
      cnt_r    <= {HOLD_W{1'b0}};
      ph_r     <= {PH_W{1'b0}};
      fcnt_r   <= {FILL_LEN_W{1'b0}};
      fadr_r   <= {ADDR_W{1'b0}};
      fdat_r   <= 16'h0000;
      fbusy_r  <= 1'b0;
      fb_a_r   <= {ADDR_W{1'b0}};
      fb_do_r  <= 16'h0000;
      fb_we_r  <= 2'b00;
      fb_rd_r  <= 1'b0;
      ack_r    <= 1'b0;
      do_r     <= 16'h0000;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      level_r  <= level_s;
      full_r   <= (level_s == LVL_W'(DEPTH));
      empty_r  <= (level_s == {LVL_W{1'b0}}) && (st_s != ST_DRAIN);
      ovf_r    <= ovf_r | (bus.H_WR && full_now_s);
      st_r     <= st_s;
      cnt_r    <= cnt_s;
      ph_r     <= ph_s;
      fcnt_r   <= fcnt_s;
      fadr_r   <= fadr_s;
      fdat_r   <= fdat_s;
      fbusy_r  <= fbusy_s;
      fb_a_r   <= fb_a_s;
      fb_do_r  <= fb_do_s;
      fb_we_r  <= fb_we_s;
      fb_rd_r  <= fb_rd_s;
      ack_r    <= ack_s;
      do_r     <= do_s;
    end
  end

  assign bus.H_FULL        = full_r;
  assign bus.H_EMPTY       = empty_r;
  assign bus.H_OVF         = ovf_r;
  assign bus.H_RD_ACK      = ack_r;
  assign bus.H_DO          = do_r;
  assign bus.FILL_BUSY     = fbusy_r;
  assign bus.FILL_ADDR_CUR = fadr_r;
  assign bus.FB_A          = fb_a_r;
  assign bus.FB_DO         = fb_do_r;
  assign bus.FB_WE         = fb_we_r;
  assign bus.FB_RD         = fb_rd_r;

endmodule

// File: doc/s32x_fb_write_engine.md
# s32x_fb_write_engine

Parametrised framebuffer write/fill engine for the 32X VDP draw side: a host write buffer with overwrite-region byte masking, an auto-fill sequencer with configurable line wrap and pacing, and a host read path that waits for all pending writes to land. It arbitrates these three sources onto one framebuffer draw port. The block sits between the SH-2/68K bus decode and the draw-side framebuffer RAM, replacing the fixed-size write FIFO and fill logic.

## Interface
- ADDR_W, 16, framebuffer word-address width
- DEPTH, 4, write FIFO entries; power of two, at least 2
- FILL_LEN_W, 8, fill length register width
- WRAP_W, 8, fill address wraps within low WRAP_W bits; WRAP_W ≤ ADDR_W
- WR_HOLD, 5, extra cycles a drain write is held; write lasts WR_HOLD+1 cycles
- RD_HOLD, 7, extra cycles a read is held; read lasts RD_HOLD+1 cycles
- FILL_PERIOD, 3, CE ticks per fill word; at least 1

Ports (reset RST_N, asynchronous, active-low; clock CLK):
- CLK  in  1  clock
- RST_N  in  1  async active-low reset
- CE  in  1  fill pacing tick
- BLOCK  in  1  framebuffer unavailable (refresh); new drain, read and fill starts are held off
- H_WR  in  1  one-cycle write push
- H_ADDR  in  ADDR_W+1  write address; MSB set selects the overwrite region
- H_DI  in  16  write data
- H_BE  in  2  byte enables {upper, lower}
- H_FULL  out  1  FIFO level equals DEPTH
- H_EMPTY  out  1  FIFO empty and no drain write in progress
- H_OVF  out  1  sticky: push attempted while full
- H_RD  in  1  read request (level); held until ack
- H_RD_ADDR  in  ADDR_W  read address
- H_RD_ACK  out  1  one-cycle read done
- H_DO  out  16  read data, valid from ack onward
- FILL_START  in  1  one-cycle fill trigger
- FILL_ADDR  in  ADDR_W  fill start address
- FILL_DATA  in  16  fill word
- FILL_LEN  in  FILL_LEN_W  words written = FILL_LEN+1
- FILL_BUSY  out  1  fill pending or executing
- FILL_ADDR_CUR  out  ADDR_W  live fill address
- FB_A  out  ADDR_W  draw-port address
- FB_DO  out  16  draw-port write data
- FB_WE  out  2  draw-port byte write enables
- FB_RD  out  1  draw-port read strobe
- FB_DI  in  16  draw-port read data

## Operation
- States: IDLE, DRAIN, READ, FILL_PEND, FILL.
- Reset: all outputs 0 except H_EMPTY=1. FIFO is emptied, H_OVF is cleared, and the state goes to IDLE. Reset mid-operation aborts any write, read or fill immediately.
- Push: H_WR with level<DEPTH stores {H_ADDR,H_BE,H_DI}. H_WR while full drops the data and sets H_OVF. A push while full is rejected even if a pop happens in the same cycle.
- IDLE priority, highest first:
  - latched fill start → FILL_PEND
  - FIFO non-empty and !BLOCK → DRAIN; pop the entry
  - H_RD and H_EMPTY and !BLOCK → READ
- FILL_START while FILL_BUSY is ignored. Otherwise it latches the address, data and length, and FILL_BUSY rises the next cycle. If DRAIN or READ is active, the fill waits until that state completes.
- DRAIN: FB_A, FB_DO and FB_WE are driven for WR_HOLD+1 cycles, then the state returns to IDLE. FB_WE is derived per lane:
  - overwrite region (MSB=1): lane written only if its BE is set and its data byte is non-zero
  - normal region: a word write (BE=11) writes both lanes; a single-byte write is suppressed if its byte is zero
- READ: FB_A=H_RD_ADDR and FB_RD=1 for RD_HOLD+1 cycles. H_DO captures FB_DI on the last cycle, and H_RD_ACK pulses the following cycle. H_RD must be low the cycle after ack; otherwise a new read starts.
- FILL_PEND: the first CE with !BLOCK enters FILL.
- FILL:
  - a phase counter counts 0..FILL_PERIOD-1 on CE
  - FB_WE=11, FB_DO=FILL_DATA and FB_A=FILL_ADDR_CUR during phase 0
  - on the CE that ends the last phase, the low WRAP_W address bits increment modulo 2^WRAP_W; upper bits are unchanged
  - the count decrements on the same CE; at count 0 the state goes to IDLE and FILL_BUSY drops
- BLOCK does not interrupt a DRAIN, READ or FILL already running.

## Timing
- Push at edge n: level and H_EMPTY update at n+1. If IDLE, DRAIN starts at n+1 with FB_WE visible from n+1 for WR_HOLD+1 cycles. A pop and a push in the same cycle leave the level unchanged.
- Read latency from the IDLE grant to H_RD_ACK is RD_HOLD+2 cycles.
- Fill of length L takes (L+1)·FILL_PERIOD CE ticks after FILL_PEND, plus one CE for FILL_PEND itself.
- FILL_ADDR_CUR is registered and updates on the increment CE.

## Test plan
- Reset during FILL with FB_WE=11 → all outputs 0, H_EMPTY=1, and no further FB_WE after reset.
- DEPTH=4: push 5 words back-to-back while BLOCK=1 → H_FULL after the 4th push, H_OVF=1, the 5th word is absent. Release BLOCK → 4 drains of 6 cycles each, in order.
- Overwrite push H_ADDR=0x1_0010, BE=11, DI=0x00A5 → FB_WE=01. Normal push BE=01, DI=0x0000 → FB_WE=00. Normal push BE=11, DI=0x0000 → FB_WE=11.
- Fill FILL_ADDR=0x12FE, LEN=3, DATA=0xBEEF, CE every cycle → writes to 0x12FE, 0x12FF, 0x1200, 0x1201; FILL_BUSY clears after 13 CE.
- Push 1 word, then immediately H_RD to the same address → read waits for the drain to complete. H_RD_ACK arrives RD_HOLD+2 cycles after the drain ends, and H_DO equals the written word when the RAM model is write-through.
- FILL_START during DRAIN plus a queued FIFO entry → the drain completes, then the fill runs, then the remaining entry drains. A second FILL_START during the fill is ignored.
